adder_arbiter: RTL



---
 rtl/adder_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder between NUM_REQ requesters.
// Optional build macro ADDER_ARB_SAT_EN: saturate the sum to WIDTH bits and add sat_flag.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  output logic [WIDTH:0]           resp_sum,
  output logic [ID_W-1:0]          resp_id,
  input  logic                     resp_ready,
  output logic                     busy
`ifdef ADDER_ARB_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, op_id, gnt_id;
  logic [WIDTH-1:0]    op_a, op_b, a_sel, b_sel;
  logic [NUM_REQ-1:0]  hi;
  logic                any_req;
  logic [WIDTH:0]      sum_full;

  // Requesters at or above rr_ptr take priority; otherwise wrap to the lowest index.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign hi[i] = req_valid[i] && (ID_W'(i) >= rr_ptr);
  end

  always_comb begin
    any_req = |req_valid;
    gnt_id  = '0;
    a_sel   = '0;
    b_sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i]) gnt_id = ID_W'(i);
    if (|hi)
      for (int i = NUM_REQ - 1; i >= 0; i--)
        if (hi[i]) gnt_id = ID_W'(i);
    for (int i = 0; i < NUM_REQ; i++)
      if (ID_W'(i) == gnt_id) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ADD;
      ADD:     state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (state == IDLE) && !reset && any_req && (ID_W'(i) == gnt_id);
  end

  assign sum_full = {1'b0, op_a} + {1'b0, op_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_id    <= '0;
`ifdef ADDER_ARB_SAT_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (any_req) begin
          op_a  <= a_sel;
          op_b  <= b_sel;
          op_id <= gnt_id;
        end
        ADD: begin
          resp_valid <= 1'b1;
          resp_id    <= op_id;
`ifdef ADDER_ARB_SAT_EN
          resp_sum   <= sum_full[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : sum_full;
          sat_flag   <= sum_full[WIDTH];
`else
          resp_sum   <= sum_full;
`endif
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          rr_ptr     <= (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
